uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Serial-to-parallel UART receiver, 8N1, LSB first; the receive-side partner of the
//   top-level transmitter stage. Consumes the serial line (idle high) and delivers one
//   byte per frame with a single-cycle valid strobe. Stop-bit violations are flagged.
//   Sits between a uio_in pin and the byte consumer (loopback into transmitter data/transmit).
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200); legal range >= 4
//   SYNC_STAGES   2    flip-flop stages in the rx input synchronizer; legal range >= 2
// PORTS
//   clk        in   1  single system clock, rising edge
//   rst        in   1  reset: synchronous, active-high
//   rx         in   1  asynchronous serial input, idle = 1
//   data       out  8  last received byte; held until the next good frame
//   valid      out  1  1-cycle strobe, data is new and stop bit was 1
//   frame_err  out  1  1-cycle strobe, stop bit sampled 0
//   busy       out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//   Reset: state=IDLE; data=8'h00; valid=0; frame_err=0; busy=0.
//     Reset synchronizer flops to 1 (idle). Bit counter and baud counter reset to 0.
//   Sync: rx passes through SYNC_STAGES flops -> rx_s. All decisions use rx_s only.
//   Baud counter: counts 0..CLKS_PER_BIT-1. Clear it on every state entry.
//   FSM:
//     IDLE : rx_s==0 -> START, busy=1.
//     START: at count==CLKS_PER_BIT/2-1 (mid start bit):
//            rx_s==0 -> DATA, bit_idx=0
//            rx_s==1 -> glitch; return to IDLE with no strobe.
//     DATA : every CLKS_PER_BIT cycles, sample rx_s into shift[bit_idx] (LSB first).
//            After bit_idx==7 is sampled -> STOP.
//     STOP : after CLKS_PER_BIT cycles (mid stop bit):
//            rx_s==1 -> data<=shift, valid=1 for one cycle
//            rx_s==0 -> frame_err=1 for one cycle; data unchanged
//            Either way -> IDLE.
//            On framing error, IDLE waits for rx_s==1 before it re-arms, so a break
//            condition does not retrigger.
//   Timing: valid asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + SYNC_STAGES + 1 cycles
//     (+/-1) after the rx falling edge.
//   Strobes: valid and frame_err are mutually exclusive and never high two cycles
//     running.
//   Back-to-back frames: a start edge immediately after the stop-sample point is
//     accepted. Because STOP ends at mid stop bit, at most a half-bit gap is needed.
//   rst asserted mid-frame: return to IDLE next cycle; no strobe; partial byte
//     discarded; data cleared to 8'h00.
//   Widths: the baud counter is $clog2(CLKS_PER_BIT) bits; bit_idx is 3 bits.
// STRUCTURE
//   Shared include (uart_defs.vh):
//     - state encodings IDLE/START/DATA/STOP (2 bits)
//     - DATA_BITS=8
//     - default CLKS_PER_BIT, shared with the transmitter so both ends agree
//   Sub-module: uart_rx_sync (parameterised SYNC_STAGES synchronizer, reset to 1).
//   The FSM, baud counter and shift register stay in this module.
// TESTING  (simulate with CLKS_PER_BIT=16)
//   1. Send 8'hA5, stop=1
//      -> exactly one valid pulse; data==8'hA5; frame_err never asserts; busy drops
//         after the pulse.
//   2. Send 8'h00 then 8'hFF back-to-back (no idle gap)
//      -> two valid pulses in order: data 8'h00, then 8'hFF.
//   3. rx low for 4 cycles then high
//      -> start rejected; no valid, no frame_err; state returns to IDLE.
//   4. Send 8'h3C with stop bit=0, hold rx low 40 cycles, then send 8'h81
//      -> one frame_err pulse; data stays at the prior value; next frame gives
//         valid with data==8'h81.
//   5. Assert rst during bit 4 of a frame
//      -> no strobe; data==8'h00; the next full frame 8'h5A is received correctly.
//   6. Loopback: transmitter tx -> rx, send 8'h00..8'hFF
//      -> 256 valid pulses, each data matching the byte sent.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM state encoding, frame width
// and default baud/synchronizer settings agreed with the transmitter.
package uart_receiver_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200
    localparam int DEFAULT_SYNC_STAGES  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: serial line in, byte/strobe/status out.
interface uart_receiver_if;
    import uart_receiver_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport slave  (input  rx, output data, output valid, output frame_err, output busy);
    modport master (output rx, input  data, input  valid, input  frame_err, input  busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle level.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first: start-bit qualification at mid bit, data sampled
// at bit centres, stop bit checked at its centre with valid/frame_err strobes.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic           clk,
    input  logic           rst,
    uart_receiver_if.slave bus
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_e       state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        brk_d     = brk_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // After a framing error the line must go high before we re-arm.
                if (rx_s)        brk_d   = 1'b0;
                else if (!brk_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == IDX_LAST) state_d   = S_STOP;
                    else                       bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                        brk_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames driven at bit rate, strobes collected and
// compared against an expected-event queue built from the frames sent.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int LAT  = CPB/2 + 9*CPB + SYNC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_receiver_if bus();

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         got_q[$];
    int         exp_q[$];
    logic [7:0] model_data = 8'h00;
    int         viol = 0;
    logic       prev_strobe = 1'b0;
    longint     t_start = 0;
    longint     t_valid = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: valid -> byte, frame_err -> 256 + data held at that moment.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            got_q.push_back(int'(bus.data));
            t_valid = $time;
        end
        if (bus.frame_err === 1'b1) got_q.push_back(256 + int'(bus.data));
        if ((bus.valid === 1'b1 && bus.frame_err === 1'b1) ||
            (prev_strobe && (bus.valid === 1'b1 || bus.frame_err === 1'b1)))
            viol++;
        prev_strobe = (bus.valid === 1'b1) || (bus.frame_err === 1'b1);
    end

    task automatic drive_bit(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        t_start = $time;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop, CPB);
        if (stop) begin
            exp_q.push_back(int'(b));
            model_data = b;
        end else begin
            exp_q.push_back(256 + int'(model_data));
        end
    endtask

    task automatic check_events(input string tag);
        repeat (2*CPB) @(posedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_event"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk({tag, "_data"}, bus.data, model_data);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         gap;
        logic [7:0] b;
        logic       stop;

        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  bus.data,      8'h00);
        chk("rst_valid", bus.valid,     1'b0);
        chk("rst_ferr",  bus.frame_err, 1'b0);
        chk("rst_busy",  bus.busy,      1'b0);
        @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // single good frame plus latency window
        send_byte(8'hA5, 1'b1);
        lat = int'((t_valid - 5 - t_start) / 10);
        $display("info: valid latency %0d cycles (nominal %0d)", lat, LAT);
        chk("t1_latency_window", (lat >= LAT-1 && lat <= LAT+1), 1'b1);
        check_events("t1");

        // back-to-back frames, no idle gap
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        check_events("t2");

        // short low glitch must not start a frame
        bus.rx = 1'b0;
        repeat (4) @(posedge clk);
        bus.rx = 1'b1;
        @(negedge clk);
        chk("t3_busy_rise", bus.busy, 1'b1);
        @(posedge clk);
        check_events("t3");

        // framing error, held break, then a good frame
        send_byte(8'h3C, 1'b0);
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 2*CPB);
        send_byte(8'h81, 1'b1);
        check_events("t4");

        // reset during bit 4 clears data and discards the partial byte
        b = 8'hC3;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
        drive_bit(b[4], CPB/2);
        rst    = 1'b1;
        bus.rx = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        model_data = 8'h00;
        check_events("t5_rst");
        send_byte(8'h5A, 1'b1);
        check_events("t5");

        // randomized frames, gaps and stop-bit errors
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            send_byte(b, stop);
            gap = stop ? int'($urandom_range(0, CPB)) : int'($urandom_range(4, CPB));
            if (gap > 0) drive_bit(1'b1, gap);
        end
        check_events("rand");

        // all byte values back-to-back
        for (int v = 0; v < 256; v++) send_byte(8'(v), 1'b1);
        check_events("loop");

        chk("strobe_rules", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
